// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Owner and state encodings plus counter widths.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  localparam int LAT_W    = 2;
  localparam int STARVE_W = 3;

endpackage

// File: rtl/mem_port_arbiter_starve.sv
// Saturating count of consecutive denied fetch cycles.
// prio flags that fetch must win the next arbitration.
module arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic gnt,
  output logic prio
);

  localparam logic [STARVE_W-1:0] MAX = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] cnt_q;
  logic [STARVE_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req || gnt) begin
      cnt_d = '0;
    end else if (cnt_q != MAX) begin
      cnt_d = cnt_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign prio = (cnt_q == MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Tracks one outstanding read and routes its data back to the owner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [LAT_W-1:0] LAT = LAT_W'(MEM_LAT);

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic             kill_q, kill_d;

  logic prio;
  logic slot;
  logic done;
  logic if_win;
  logic d_win;

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .req (if_req),
    .gnt (if_gnt),
    .prio(prio)
  );

  // The last wait cycle doubles as a fresh arbitration slot.
  always_comb begin
    done   = (state_q == RD_WAIT) && (cnt_q == LAT);
    slot   = (state_q == IDLE) || done;
    if_win = rst && slot && if_req && (!d_req || prio);
    d_win  = rst && slot && d_req && !if_win;
  end

  always_comb begin
    if_gnt    = if_win;
    d_gnt     = d_win;
    mem_en    = if_win || d_win;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_win) begin
      mem_addr = if_addr;
    end else if (d_win) begin
      mem_addr  = d_addr;
      mem_we    = d_we;
      mem_wdata = d_wdata;
    end
    if_rvalid = done && (owner_q == OWN_IF)
                && !kill_q && !if_kill;
    d_rvalid  = done && (owner_q == OWN_D);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid ? mem_rdata : '0;
    busy      = (state_q == RD_WAIT);
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    kill_d  = kill_q;
    if (done) begin
      state_d = IDLE;
      owner_d = OWN_NONE;
      cnt_d   = '0;
      kill_d  = 1'b0;
    end else if (state_q == RD_WAIT) begin
      cnt_d  = cnt_q + LAT_W'(1);
      kill_d = kill_q || (if_kill && owner_q == OWN_IF);
    end
    if (if_win || (d_win && !d_we)) begin
      state_d = RD_WAIT;
      owner_d = if_win ? OWN_IF : OWN_D;
      cnt_d   = LAT_W'(1);
      kill_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiters with MEM_LAT 1..3 share one stimulus.
// Each has its own registered read-latency memory model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       if_req = 1'b0;
  logic       if_kill = 1'b0;
  logic       d_req = 1'b0;
  logic       d_we = 1'b0;
  logic [7:0] if_addr = '0;
  logic [7:0] d_addr = '0;
  logic [7:0] d_wdata = '0;

  logic       if_gnt    [1:3];
  logic       if_rvalid [1:3];
  logic       d_gnt     [1:3];
  logic       d_rvalid  [1:3];
  logic       mem_en    [1:3];
  logic       mem_we    [1:3];
  logic       busy      [1:3];
  logic [7:0] if_rdata  [1:3];
  logic [7:0] d_rdata   [1:3];
  logic [7:0] mem_addr  [1:3];
  logic [7:0] mem_wdata [1:3];
  logic [7:0] mem_rdata [1:3];

  int errors = 0;
  int checks = 0;

  function automatic logic [7:0] memval(input logic [7:0] a);
    case (a)
      8'h10:   memval = 8'h5A;
      8'h80:   memval = 8'h33;
      default: memval = a ^ 8'hC3;
    endcase
  endfunction

  for (genvar L = 1; L <= 3; L++) begin : g
    logic [7:0] pipe [1:3];

    mem_port_arbiter #(
      .ADDR_W(8),
      .DATA_W(8),
      .MEM_LAT(L),
      .STARVE_MAX(3)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_kill  (if_kill),
      .if_gnt   (if_gnt[L]),
      .if_rvalid(if_rvalid[L]),
      .if_rdata (if_rdata[L]),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_gnt    (d_gnt[L]),
      .d_rvalid (d_rvalid[L]),
      .d_rdata  (d_rdata[L]),
      .mem_en   (mem_en[L]),
      .mem_we   (mem_we[L]),
      .mem_addr (mem_addr[L]),
      .mem_wdata(mem_wdata[L]),
      .mem_rdata(mem_rdata[L]),
      .busy     (busy[L])
    );

    always_ff @(posedge clk) begin
      pipe[1] <= (mem_en[L] && !mem_we[L]) ? memval(mem_addr[L]) : 8'hEE;
      pipe[2] <= pipe[1];
      pipe[3] <= pipe[2];
    end

    assign mem_rdata[L] = pipe[L];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    if_req  = 1'b0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    if_kill = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_reset;
    rst     = 1'b0;
    if_req  = 1'b1;
    if_addr = 8'h10;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 8'h20;
    d_wdata = 8'h55;
    @(negedge clk);
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if ({if_gnt[i], d_gnt[i], if_rvalid[i], d_rvalid[i],
           mem_en[i], mem_we[i], busy[i]} !== 7'b0 ||
          mem_addr[i] !== 8'h00 || mem_wdata[i] !== 8'h00 ||
          if_rdata[i] !== 8'h00 || d_rdata[i] !== 8'h00) begin
        errors++;
        $display("FAIL reset_outs inst=%0d gnt=%b/%b en=%b we=%b busy=%b addr=%h wdata=%h exp all 0",
                 i, if_gnt[i], d_gnt[i], mem_en[i], mem_we[i],
                 busy[i], mem_addr[i], mem_wdata[i]);
      end
    end
    step();
    if_req = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;
    rst    = 1'b1;
    repeat (2) begin
      @(negedge clk);
      for (int i = 1; i <= 3; i++) begin
        checks++;
        if (mem_en[i] !== 1'b0 || busy[i] !== 1'b0) begin
          errors++;
          $display("FAIL reset_release inst=%0d mem_en=%b busy=%b exp 0 0",
                   i, mem_en[i], busy[i]);
        end
      end
      step();
    end
  endtask

  task automatic test_fetch_read;
    if_req  = 1'b1;
    if_addr = 8'h10;
    @(negedge clk);
    checks++;
    if (if_gnt[2] !== 1'b1 || mem_addr[2] !== 8'h10 ||
        mem_en[2] !== 1'b1 || mem_we[2] !== 1'b0) begin
      errors++;
      $display("FAIL fetch_gnt gnt=%b en=%b we=%b addr=%h exp 1 1 0 10",
               if_gnt[2], mem_en[2], mem_we[2], mem_addr[2]);
    end
    step();
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_rvalid[2] !== 1'b0 || busy[2] !== 1'b1 || d_rvalid[2] !== 1'b0) begin
      errors++;
      $display("FAIL fetch_wait rvalid=%b busy=%b d_rvalid=%b exp 0 1 0",
               if_rvalid[2], busy[2], d_rvalid[2]);
    end
    checks++;
    if (if_rvalid[1] !== 1'b1 || if_rdata[1] !== 8'h5A) begin
      errors++;
      $display("FAIL fetch_lat1 rvalid=%b rdata=%h exp 1 5a",
               if_rvalid[1], if_rdata[1]);
    end
    step();
    @(negedge clk);
    checks++;
    if (if_rvalid[2] !== 1'b1 || if_rdata[2] !== 8'h5A || d_rvalid[2] !== 1'b0) begin
      errors++;
      $display("FAIL fetch_data rvalid=%b rdata=%h d_rvalid=%b exp 1 5a 0",
               if_rvalid[2], if_rdata[2], d_rvalid[2]);
    end
    step();
    @(negedge clk);
    checks++;
    if (busy[2] !== 1'b0 || if_rvalid[2] !== 1'b0) begin
      errors++;
      $display("FAIL fetch_done busy=%b rvalid=%b exp 0 0", busy[2], if_rvalid[2]);
    end
    idle();
  endtask

  task automatic test_conflict;
    if_req  = 1'b1;
    if_addr = 8'h10;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 8'h80;
    @(negedge clk);
    checks++;
    if (d_gnt[2] !== 1'b1 || if_gnt[2] !== 1'b0 || mem_addr[2] !== 8'h80) begin
      errors++;
      $display("FAIL conflict_gnt d_gnt=%b if_gnt=%b addr=%h exp 1 0 80",
               d_gnt[2], if_gnt[2], mem_addr[2]);
    end
    step();
    d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_gnt[2] !== 1'b0 || mem_en[2] !== 1'b0) begin
      errors++;
      $display("FAIL conflict_hold if_gnt=%b mem_en=%b exp 0 0",
               if_gnt[2], mem_en[2]);
    end
    step();
    @(negedge clk);
    checks++;
    if (d_rvalid[2] !== 1'b1 || d_rdata[2] !== 8'h33 ||
        if_gnt[2] !== 1'b1 || mem_addr[2] !== 8'h10 || if_rdata[2] !== 8'h00) begin
      errors++;
      $display("FAIL conflict_slot d_rvalid=%b d_rdata=%h if_gnt=%b addr=%h if_rdata=%h exp 1 33 1 10 00",
               d_rvalid[2], d_rdata[2], if_gnt[2], mem_addr[2], if_rdata[2]);
    end
    step();
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_rvalid[2] !== 1'b0 || busy[2] !== 1'b1) begin
      errors++;
      $display("FAIL conflict_wait rvalid=%b busy=%b exp 0 1",
               if_rvalid[2], busy[2]);
    end
    step();
    @(negedge clk);
    checks++;
    if (if_rvalid[2] !== 1'b1 || if_rdata[2] !== 8'h5A || d_rvalid[2] !== 1'b0) begin
      errors++;
      $display("FAIL conflict_fetch rvalid=%b rdata=%h d_rvalid=%b exp 1 5a 0",
               if_rvalid[2], if_rdata[2], d_rvalid[2]);
    end
    idle();
  endtask

  task automatic test_starvation;
    if_req  = 1'b1;
    if_addr = 8'h40;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 8'h20;
    d_wdata = 8'h77;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (c == 3) begin
        if (if_gnt[1] !== 1'b1 || d_gnt[1] !== 1'b0 ||
            mem_we[1] !== 1'b0 || mem_addr[1] !== 8'h40) begin
          errors++;
          $display("FAIL starve_cyc%0d if_gnt=%b d_gnt=%b we=%b addr=%h exp 1 0 0 40",
                   c, if_gnt[1], d_gnt[1], mem_we[1], mem_addr[1]);
        end
      end else begin
        if (d_gnt[1] !== 1'b1 || if_gnt[1] !== 1'b0 || mem_we[1] !== 1'b1 ||
            mem_addr[1] !== 8'h20 || mem_wdata[1] !== 8'h77) begin
          errors++;
          $display("FAIL starve_cyc%0d d_gnt=%b if_gnt=%b we=%b addr=%h wdata=%h exp 1 0 1 20 77",
                   c, d_gnt[1], if_gnt[1], mem_we[1], mem_addr[1], mem_wdata[1]);
        end
      end
      if (c == 4) begin
        checks++;
        if (if_rvalid[1] !== 1'b1 || if_rdata[1] !== 8'h83 || d_rvalid[1] !== 1'b0) begin
          errors++;
          $display("FAIL starve_rdata rvalid=%b rdata=%h d_rvalid=%b exp 1 83 0",
                   if_rvalid[1], if_rdata[1], d_rvalid[1]);
        end
      end
      step();
    end
    idle();
  endtask

  task automatic test_kill;
    if_req  = 1'b1;
    if_addr = 8'h10;
    @(negedge clk);
    checks++;
    if (if_gnt[2] !== 1'b1) begin
      errors++;
      $display("FAIL kill_gnt if_gnt=%b exp 1", if_gnt[2]);
    end
    step();
    if_req  = 1'b0;
    if_kill = 1'b1;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 8'h80;
    @(negedge clk);
    checks++;
    if (d_gnt[2] !== 1'b0 || busy[2] !== 1'b1 || mem_en[2] !== 1'b0) begin
      errors++;
      $display("FAIL kill_hold d_gnt=%b busy=%b mem_en=%b exp 0 1 0",
               d_gnt[2], busy[2], mem_en[2]);
    end
    checks++;
    if (if_rvalid[1] !== 1'b0 || if_rdata[1] !== 8'h00) begin
      errors++;
      $display("FAIL kill_same_cycle rvalid=%b rdata=%h exp 0 00",
               if_rvalid[1], if_rdata[1]);
    end
    step();
    if_kill = 1'b0;
    @(negedge clk);
    checks++;
    if (if_rvalid[2] !== 1'b0 || d_gnt[2] !== 1'b1 || mem_addr[2] !== 8'h80) begin
      errors++;
      $display("FAIL kill_suppress if_rvalid=%b d_gnt=%b addr=%h exp 0 1 80",
               if_rvalid[2], d_gnt[2], mem_addr[2]);
    end
    step();
    d_req = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if (d_rvalid[2] !== 1'b1 || d_rdata[2] !== 8'h33 || if_rvalid[2] !== 1'b0) begin
      errors++;
      $display("FAIL kill_data_load d_rvalid=%b d_rdata=%h if_rvalid=%b exp 1 33 0",
               d_rvalid[2], d_rdata[2], if_rvalid[2]);
    end
    idle();
  endtask

  task automatic test_back_to_back;
    if_req  = 1'b1;
    if_addr = 8'h10;
    @(negedge clk);
    checks++;
    if (if_gnt[2] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gnt0 if_gnt=%b exp 1", if_gnt[2]);
    end
    step();
    if_addr = 8'h80;
    step();
    @(negedge clk);
    checks++;
    if (if_rvalid[2] !== 1'b1 || if_rdata[2] !== 8'h5A ||
        if_gnt[2] !== 1'b1 || mem_addr[2] !== 8'h80) begin
      errors++;
      $display("FAIL b2b_slot rvalid=%b rdata=%h gnt=%b addr=%h exp 1 5a 1 80",
               if_rvalid[2], if_rdata[2], if_gnt[2], mem_addr[2]);
    end
    step();
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (busy[2] !== 1'b1 || if_rvalid[2] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy busy=%b rvalid=%b exp 1 0", busy[2], if_rvalid[2]);
    end
    step();
    @(negedge clk);
    checks++;
    if (if_rvalid[2] !== 1'b1 || if_rdata[2] !== 8'h33) begin
      errors++;
      $display("FAIL b2b_second rvalid=%b rdata=%h exp 1 33",
               if_rvalid[2], if_rdata[2]);
    end
    idle();
  endtask

  task automatic test_reset_mid_read;
    if_req  = 1'b1;
    if_addr = 8'h10;
    @(negedge clk);
    checks++;
    if (if_gnt[3] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_gnt if_gnt=%b exp 1", if_gnt[3]);
    end
    step();
    if_req = 1'b0;
    rst    = 1'b0;
    #1;
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (busy[i] !== 1'b0 || if_rvalid[i] !== 1'b0) begin
        errors++;
        $display("FAIL midrst_busy inst=%0d busy=%b rvalid=%b exp 0 0",
                 i, busy[i], if_rvalid[i]);
      end
    end
    step();
    rst = 1'b1;
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      for (int i = 1; i <= 3; i++) begin
        checks++;
        if (if_rvalid[i] !== 1'b0 || d_rvalid[i] !== 1'b0 || busy[i] !== 1'b0) begin
          errors++;
          $display("FAIL midrst_quiet inst=%0d cyc=T+%0d rvalid=%b/%b busy=%b exp 0",
                   i, c, if_rvalid[i], d_rvalid[i], busy[i]);
        end
      end
      step();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_conflict();
    test_starvation();
    test_kill();
    test_back_to_back();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
